priority_dec: RTL and testbench



---
 rtl/priority_dec_pkg.sv | 24 ++
 rtl/priority_dec_idx_to_onehot.sv | 25 ++
 rtl/priority_dec.sv | 133 +++++++++++++
 tb/tb_priority_dec.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_dec_pkg.sv
// priority_dec_pkg
// Shared constants and state encoding for the register-list priority decoder.
// The mask width agrees with the register-list priority encoder, so both
// sides of the load/store-multiple path build and consume 8-bit masks.
//
// Contents:
//   MASK_W  - register-list mask width (fixed at 8)
//   IDX_W   - register index width, log2(MASK_W)
//   CNT_W   - width of the distinct-bit counter (holds 0..8)
//   state_t - decoder FSM state encoding

package priority_dec_pkg;

    localparam int MASK_W = 8;
    localparam int IDX_W  = 3;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

endpackage : priority_dec_pkg

// File: rtl/priority_dec_idx_to_onehot.sv
// priority_dec_idx_to_onehot
// Purely combinational 3-to-8 decoder: turns a register index into a one-hot
// vector. Kept separate so it can be reused for register-file write enables.
//
// Ports:
//   idx    in  [IDX_W-1:0]  register index
//   onehot out [MASK_W-1:0] one-hot decode, bit idx set

module priority_dec_idx_to_onehot
    import priority_dec_pkg::*;
(
    input  logic [IDX_W-1:0]  idx,
    output logic [MASK_W-1:0] onehot
);

    // Each output bit compares the index against its own position, which keeps
    // the decode free of shifts and trivially width-clean.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < MASK_W; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    end

endmodule : priority_dec_idx_to_onehot

// File: rtl/priority_dec.sv
// priority_dec
// Rebuilds register-list masks from a stream of register indices. Each
// accepted index is decoded to one-hot and ORed into a mask; the index marked
// in_last closes the burst and the finished mask is offered downstream.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   in_valid    in   in_idx / in_last valid
//   in_ready    out  block can accept an index this cycle
//   in_idx      in   [2:0] register index
//   in_last     in   final index of the burst
//   out_valid   out  out_mask / out_count / dup_err valid
//   out_ready   in   downstream consumes the mask
//   out_mask    out  [7:0] accumulated register-list mask
//   out_onehot  out  [7:0] one-hot of the most recently accepted index
//   out_count   out  [3:0] number of distinct bits set in out_mask
//   dup_err     out  an index was repeated within the burst (sticky)
//
// Build option:
//   PRIORITY_DEC_BYPASS_EN - while presenting, accept the first index of the
//   next burst in the same cycle as the output handshake (no idle bubble).

module priority_dec
    import priority_dec_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IDX_W-1:0]  in_idx,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MASK_W-1:0] out_mask,
    output logic [MASK_W-1:0] out_onehot,
    output logic [CNT_W-1:0]  out_count,
    output logic              dup_err
);

    state_t            state_q;
    state_t            state_d;
    logic [MASK_W-1:0] onehot;
    logic              accept;
    logic              hit;
    logic              new_burst;

    priority_dec_idx_to_onehot u_idx_to_onehot (
        .idx    (in_idx),
        .onehot (onehot)
    );

    // Input readiness depends only on the registered state (plus out_ready
    // when bypassing), so there is no combinational path from in_valid.
`ifdef PRIORITY_DEC_BYPASS_EN
    assign in_ready = (state_q != ST_PRESENT) | out_ready;
`else
    assign in_ready = (state_q != ST_PRESENT);
`endif

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_PRESENT);

    // A burst is only open while collecting; an accept in any other state
    // (idle, or presenting with bypass) is the first index of a new burst.
    assign new_burst = (state_q != ST_COLLECT);
    assign hit       = |(out_mask & onehot);

    // Next-state logic: a burst opens on the first accept, closes on the
    // accept carrying in_last, and is released by the output handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = in_last ? ST_PRESENT : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept && in_last) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (accept) begin
                        state_d = in_last ? ST_PRESENT : ST_COLLECT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons any open burst or pending mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accumulator and counter. A new burst restarts from the current index
    // alone; within a burst a repeated index raises dup_err and leaves the
    // count alone, which is what keeps the count bounded at 8. Everything
    // holds while no index is accepted, which covers the whole presentation.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_mask   <= '0;
            out_onehot <= '0;
            out_count  <= '0;
            dup_err    <= 1'b0;
        end else if (accept) begin
            out_onehot <= onehot;
            if (new_burst) begin
                out_mask  <= onehot;
                out_count <= CNT_W'(1);
                dup_err   <= 1'b0;
            end else if (hit) begin
                dup_err   <= 1'b1;
            end else begin
                out_mask  <= out_mask | onehot;
                out_count <= out_count + CNT_W'(1);
            end
        end
    end

endmodule : priority_dec

// File: tb/tb_priority_dec.sv
// tb_priority_dec
// Self-checking bench for priority_dec. A reference model tracks the burst
// being built from the indices the bench drives and pushes the expected
// mask/count/dup_err into a scoreboard when the last index goes in; each
// scenario pops that entry when the DUT presents its mask.

module tb_priority_dec;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_idx;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_mask;
    logic [7:0] out_onehot;
    logic [3:0] out_count;
    logic       dup_err;

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] count;
        logic       dup;
    } exp_t;

    exp_t sb[$];

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] model_mask;
    logic [3:0] model_count;
    logic       model_dup;
    logic       model_open;

    priority_dec dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_idx     (in_idx),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mask   (out_mask),
        .out_onehot (out_onehot),
        .out_count  (out_count),
        .dup_err    (dup_err)
    );

    always #5 clk = ~clk;

    // Reference model of one accepted index; pushes the finished burst.
    task automatic model_accept(input logic [2:0] idx, input logic last);
        logic [7:0] oh;
        oh = 8'h01 << idx;
        if (!model_open) begin
            model_mask  = oh;
            model_count = 4'd1;
            model_dup   = 1'b0;
        end else if ((model_mask & oh) != 8'h00) begin
            model_dup = 1'b1;
        end else begin
            model_mask  = model_mask | oh;
            model_count = model_count + 4'd1;
        end
        model_open = !last;
        if (last) begin
            sb.push_back('{mask: model_mask, count: model_count, dup: model_dup});
        end
    endtask

    // Drive one index starting at posedge+1; waits (bounded) for in_ready and
    // returns at posedge+1 just after the accepting edge.
    task automatic drive_idx(input logic [2:0] idx, input logic last);
        int n;
        in_valid = 1'b1;
        in_idx   = idx;
        in_last  = last;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: in_ready got %b expected 1 (idx %0d)", in_ready, idx);
        end
        @(posedge clk);
        #1;
        model_accept(idx, last);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pop_expected(output exp_t e);
        if (sb.size() == 0) begin
            e = '0;
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_open = 1'b0;
        @(negedge clk);
        compared++;
        if ({in_ready, out_valid, out_mask, out_onehot, out_count, dup_err} !== {1'b1, 1'b0, 8'h00, 8'h00, 4'd0, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b mask=%h oh=%h cnt=%0d dup=%b expected rdy=1 vld=0 mask=00 oh=00 cnt=0 dup=0",
                     in_ready, out_valid, out_mask, out_onehot, out_count, dup_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        exp_t e;
        out_ready = 1'b1;
        drive_idx(3'd5, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL single_out: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        compared++;
        if (out_onehot !== 8'h20) begin
            mismatched++;
            $display("[TB] FAIL single_onehot: got %h expected 20", out_onehot);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if ({out_valid, in_ready} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL single_drop: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        exp_t e;
        out_ready = 1'b0;
        drive_idx(3'd0, 1'b0);
        drive_idx(3'd3, 1'b0);
        drive_idx(3'd7, 1'b1);
        pop_expected(e);
        in_valid = 1'b1;
        in_idx   = 3'd5;
        in_last  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            compared++;
            if ({out_valid, in_ready, out_mask, out_count, dup_err, out_onehot} !== {1'b1, 1'b0, e.mask, e.count, e.dup, 8'h80}) begin
                mismatched++;
                $display("[TB] FAIL hold_cycle%0d: got vld=%b rdy=%b mask=%h cnt=%0d dup=%b oh=%h expected vld=1 rdy=0 mask=%h cnt=%0d dup=%b oh=80",
                         c, out_valid, in_ready, out_mask, out_count, dup_err, out_onehot, e.mask, e.count, e.dup);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if ({out_valid, out_mask} !== {1'b0, 8'h89}) begin
            mismatched++;
            $display("[TB] FAIL hold_release: got vld=%b mask=%h expected vld=0 mask=89", out_valid, out_mask);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_dup();
        exp_t e;
        out_ready = 1'b1;
        drive_idx(3'd2, 1'b0);
        drive_idx(3'd2, 1'b0);
        drive_idx(3'd4, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL dup_burst: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
        drive_idx(3'd1, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL dup_cleared: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_all_eight();
        exp_t e;
        out_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            drive_idx(3'(i), 1'b0);
        end
        drive_idx(3'd3, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL all_eight: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        exp_t e;
        out_ready = 1'b1;
        drive_idx(3'd1, 1'b0);
        drive_idx(3'd6, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_open = 1'b0;
        @(negedge clk);
        compared++;
        if ({out_valid, in_ready, out_mask, out_count, dup_err, out_onehot} !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 8'h00}) begin
            mismatched++;
            $display("[TB] FAIL mid_reset: got vld=%b rdy=%b mask=%h cnt=%0d dup=%b oh=%h expected vld=0 rdy=1 mask=00 cnt=0 dup=0 oh=00",
                     out_valid, in_ready, out_mask, out_count, dup_err, out_onehot);
        end
        @(posedge clk); #1;
        drive_idx(3'd4, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL after_reset: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        out_ready = 1'b0;
        drive_idx(3'd1, 1'b1);
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err} !== {1'b1, e.mask, e.count, e.dup}) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got vld=%b mask=%h cnt=%0d dup=%b expected vld=1 mask=%h cnt=%0d dup=%b",
                     out_valid, out_mask, out_count, dup_err, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_idx    = 3'd6;
        in_last   = 1'b1;
        @(negedge clk);
`ifdef PRIORITY_DEC_BYPASS_EN
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_bypass_ready: got %b expected 1", in_ready);
        end
        @(posedge clk); #1;
`else
        compared++;
        if (in_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_present_ready: got %b expected 0", in_ready);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if ({out_valid, in_ready} !== 2'b01) begin
            mismatched++;
            $display("[TB] FAIL b2b_bubble: got vld=%b rdy=%b expected vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
`endif
        model_accept(3'd6, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        pop_expected(e);
        compared++;
        if ({out_valid, out_mask, out_count, dup_err, out_onehot} !== {1'b1, e.mask, e.count, e.dup, 8'h40}) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got vld=%b mask=%h cnt=%0d dup=%b oh=%h expected vld=1 mask=%h cnt=%0d dup=%b oh=40",
                     out_valid, out_mask, out_count, dup_err, out_onehot, e.mask, e.count, e.dup);
        end
        @(posedge clk); #1;
        @(negedge clk);
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL b2b_drain: got vld=%b expected 0", out_valid);
        end
        @(posedge clk); #1;
    endtask

    // Scenario sequence; each one starts and ends just after a rising edge.
    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_idx      = 3'd0;
        in_last     = 1'b0;
        out_ready   = 1'b0;
        model_mask  = 8'h00;
        model_count = 4'd0;
        model_dup   = 1'b0;
        model_open  = 1'b0;
        #1;
        test_reset();
        test_single();
        test_hold();
        test_dup();
        test_all_eight();
        test_mid_reset();
        test_back_to_back();
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_priority_dec
